// File: rtl/instruction_queue.sv
// instruction_queue: circular FIFO between the instruction decoder and the
// reservation-station dispatch logic. It holds decoded instructions in
// arrival order and also keeps a running count of buffered control-flow
// (branch) entries. A flush discards everything, e.g. on a branch mispredict.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous reset, active-low (queue empty while low)
//   flush_i      discard all entries at the next edge (beats enq/deq)
//   enq_vld_i    decoder presents enq_instr_i
//   enq_instr_i  instruction from the decoder
//   enq_rdy_o    queue can accept an entry this cycle (= !full_o)
//   deq_vld_o    deq_instr_o holds the oldest entry (= !empty_o)
//   deq_instr_o  oldest entry, read straight out of storage
//   deq_rdy_i    dispatch consumes the oldest entry this cycle
//   count_o      number of occupied entries
//   br_count_o   occupied entries whose branch flag is set
//   full_o       count_o == DEPTH
//   empty_o      count_o == 0

package instruction_queue_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  opcode;
    logic [4:0]  rd;
    logic        branch;
  } instruction_element_t;
endpackage

module instruction_queue
  import instruction_queue_pkg::*;
#(
  parameter int  DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 enq_vld_i,
  input  instruction_element_t enq_instr_i,
  output logic                 enq_rdy_o,
  output logic                 deq_vld_o,
  output instruction_element_t deq_instr_o,
  input  logic                 deq_rdy_i,
  output logic [PTR_W:0]       count_o,
  output logic [PTR_W:0]       br_count_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

  // Pointers carry one extra MSB that toggles on every wrap, so full and
  // empty can be told apart when the indices coincide.
  logic [PTR_W:0] head_reg, head_next;
  logic [PTR_W:0] tail_reg, tail_next;
  logic [PTR_W:0] br_count_reg, br_count_next;

  instruction_element_t mem [DEPTH];

  logic full, empty;
  logic enq_fire, deq_fire;
  logic enq_is_br, deq_is_br;

  assign full  = (head_reg[PTR_W-1:0] == tail_reg[PTR_W-1:0]) &&
                 (head_reg[PTR_W] != tail_reg[PTR_W]);
  assign empty = (head_reg == tail_reg);

  assign enq_rdy_o   = !full;
  assign deq_vld_o   = !empty;
  assign full_o      = full;
  assign empty_o     = empty;
  // Modular difference of the extended pointers is the occupancy (0..DEPTH).
  assign count_o     = tail_reg - head_reg;
  assign br_count_o  = br_count_reg;
  assign deq_instr_o = mem[head_reg[PTR_W-1:0]];

  // Flush suppresses both handshakes so neither storage nor counters move.
  assign enq_fire  = enq_vld_i && !full && !flush_i;
  assign deq_fire  = deq_vld_o && deq_rdy_i && !flush_i;
  assign enq_is_br = enq_fire && enq_instr_i.branch;
  assign deq_is_br = deq_fire && deq_instr_o.branch;

  always_comb begin
    head_next     = head_reg;
    tail_next     = tail_reg;
    br_count_next = br_count_reg;
    if (flush_i) begin
      head_next     = '0;
      tail_next     = '0;
      br_count_next = '0;
    end else begin
      if (enq_fire) tail_next = tail_reg + PTR_ONE;
      if (deq_fire) head_next = head_reg + PTR_ONE;
      // A branch entering and a branch leaving in one cycle cancel out.
      case ({enq_is_br, deq_is_br})
        2'b10:   br_count_next = br_count_reg + PTR_ONE;
        2'b01:   br_count_next = br_count_reg - PTR_ONE;
        default: br_count_next = br_count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_reg     <= '0;
      tail_reg     <= '0;
      br_count_reg <= '0;
    end else begin
      head_reg     <= head_next;
      tail_reg     <= tail_next;
      br_count_reg <= br_count_next;
    end
  end

  // Storage is deliberately not reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      mem[tail_reg[PTR_W-1:0]] <= enq_instr_i;
    end
  end

endmodule

// File: tb/tb_instruction_queue.sv
module tb_instruction_queue;
  import instruction_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 flush_i = 1'b0;
  logic                 enq_vld_i = 1'b0;
  instruction_element_t enq_instr_i = '0;
  logic                 enq_rdy_o;
  logic                 deq_vld_o;
  instruction_element_t deq_instr_o;
  logic                 deq_rdy_i = 1'b0;
  logic [PTR_W:0]       count_o;
  logic [PTR_W:0]       br_count_o;
  logic                 full_o;
  logic                 empty_o;

  instruction_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .enq_vld_i(enq_vld_i), .enq_instr_i(enq_instr_i), .enq_rdy_o(enq_rdy_o),
    .deq_vld_o(deq_vld_o), .deq_instr_o(deq_instr_o), .deq_rdy_i(deq_rdy_i),
    .count_o(count_o), .br_count_o(br_count_o),
    .full_o(full_o), .empty_o(empty_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the queue contents as a plain ordered list.
  instruction_element_t mq[$];
  // Scoreboard: entries expected to leave the DUT, in order.
  instruction_element_t exp_q[$];

  task automatic check(string name, logic [63:0] act, logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic int model_br();
    int n = 0;
    foreach (mq[i]) if (mq[i].branch) n++;
    return n;
  endfunction

  function automatic instruction_element_t mk(logic [31:0] pc, logic br);
    instruction_element_t e;
    e.pc     = pc;
    e.opcode = 8'($urandom);
    e.rd     = 5'($urandom);
    e.branch = br;
    return e;
  endfunction

  // One clock of stimulus. Inputs change just after the falling edge; the
  // model advances at the rising edge from queue-level rules.
  task automatic cycle(logic v, instruction_element_t e, logic r, logic f);
    bit ef, df;
    @(negedge clk);
    #1;
    enq_vld_i   = v;
    enq_instr_i = e;
    deq_rdy_i   = r;
    flush_i     = f;
    ef = v && (mq.size() < DEPTH) && !f;
    df = r && (mq.size() > 0) && !f;
    if (f) exp_q.delete();
    else if (ef) exp_q.push_back(e);
    @(posedge clk);
    if (f) mq.delete();
    else begin
      if (df) void'(mq.pop_front());
      if (ef) mq.push_back(e);
    end
    $display("cyc enq=%b pc=%h br=%b rdy=%b flush=%b -> enq_fire=%b deq_fire=%b model_cnt=%0d",
             v, e.pc, e.branch, r, f, ef, df, mq.size());
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  // Monitor: after the driver has settled the inputs, compare the visible
  // state with the model and pop the scoreboard on every dequeue handshake.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      check("count", 64'(count_o), 64'(mq.size()));
      check("br_count", 64'(br_count_o), 64'(model_br()));
      check("full", 64'(full_o), 64'(mq.size() == DEPTH));
      check("empty", 64'(empty_o), 64'(mq.size() == 0));
      check("enq_rdy", 64'(enq_rdy_o), 64'(mq.size() < DEPTH));
      check("deq_vld", 64'(deq_vld_o), 64'(mq.size() > 0));
      check("br_le_count", 64'(br_count_o <= count_o), 64'(1));
      if (mq.size() > 0) check("head", 64'(deq_instr_o), 64'(mq[0]));
      if (rst && deq_vld_o && deq_rdy_i && !flush_i) begin
        if (exp_q.size() == 0) check("deq_unexpected", 64'(deq_instr_o.pc), 64'hDEAD);
        else check("deq_data", 64'(deq_instr_o), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic async_reset_check();
    @(negedge clk);
    #1;
    enq_vld_i = 1'b0;
    deq_rdy_i = 1'b0;
    flush_i   = 1'b0;
    #3;
    rst = 1'b0;
    mq.delete();
    exp_q.delete();
    #1;
    check("arst_count", 64'(count_o), 64'(0));
    check("arst_br", 64'(br_count_o), 64'(0));
    check("arst_empty", 64'(empty_o), 64'(1));
    check("arst_full", 64'(full_o), 64'(0));
    check("arst_deq_vld", 64'(deq_vld_o), 64'(0));
    check("arst_enq_rdy", 64'(enq_rdy_o), 64'(1));
    @(negedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] pc;
    #1;
    check("rst_count", 64'(count_o), 64'(0));
    check("rst_empty", 64'(empty_o), 64'(1));
    check("rst_enq_rdy", 64'(enq_rdy_o), 64'(1));
    check("rst_deq_vld", 64'(deq_vld_o), 64'(0));
    @(negedge clk);
    #1;
    rst = 1'b1;

    // Three entries, nothing consumed; head visible one cycle after the write.
    cycle(1'b1, mk(32'h100, 1'b0), 1'b0, 1'b0);
    #1;
    check("lat_deq_vld", 64'(deq_vld_o), 64'(1));
    check("lat_pc", 64'(deq_instr_o.pc), 64'h100);
    cycle(1'b1, mk(32'h104, 1'b0), 1'b0, 1'b0);
    cycle(1'b1, mk(32'h108, 1'b0), 1'b0, 1'b0);
    idle();

    // Fill to full, then enq+deq together: only the dequeue fires.
    for (int i = 0; i < 5; i++) cycle(1'b1, mk(32'h10C + 32'(4 * i), 1'b0), 1'b0, 1'b0);
    idle();
    cycle(1'b1, mk(32'h1FC, 1'b0), 1'b1, 1'b0);
    idle();
    drain();

    // Streaming with wrap-around: occupancy stays at 3 throughout.
    pc = 32'h1000;
    for (int i = 0; i < 3; i++) begin cycle(1'b1, mk(pc, 1'b0), 1'b0, 1'b0); pc += 4; end
    for (int i = 0; i < 20; i++) begin cycle(1'b1, mk(pc, 1'(i % 3 == 0)), 1'b1, 1'b0); pc += 4; end
    drain();

    // Branch accounting: branch leaves as a non-branch enters.
    cycle(1'b1, mk(32'h300, 1'b1), 1'b0, 1'b0);
    cycle(1'b1, mk(32'h304, 1'b0), 1'b0, 1'b0);
    cycle(1'b1, mk(32'h308, 1'b1), 1'b0, 1'b0);
    cycle(1'b1, mk(32'h30C, 1'b0), 1'b0, 1'b0);
    cycle(1'b1, mk(32'h310, 1'b0), 1'b0, 1'b0);
    idle();
    cycle(1'b1, mk(32'h314, 1'b0), 1'b1, 1'b0);
    idle();

    // Flush with 4 entries while enq and deq are both presented.
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b1, mk(32'hBAD0, 1'b1), 1'b1, 1'b1);
    idle();
    cycle(1'b1, mk(32'h400, 1'b0), 1'b0, 1'b0);
    cycle(1'b1, mk(32'h404, 1'b1), 1'b0, 1'b0);
    drain();

    // Asynchronous reset with 6 entries queued.
    for (int i = 0; i < 6; i++) cycle(1'b1, mk(32'h500 + 32'(4 * i), 1'(i[0])), 1'b0, 1'b0);
    async_reset_check();
    cycle(1'b1, mk(32'h200, 1'b0), 1'b0, 1'b0);
    cycle(1'b1, mk(32'h204, 1'b1), 1'b0, 1'b0);
    #1;
    check("post_rst_head", 64'(deq_instr_o.pc), 64'h200);
    drain();

    // Randomized traffic.
    pc = 32'h8000;
    for (int i = 0; i < 400; i++) begin
      logic v, r, f, b;
      v = 1'($urandom_range(0, 99) < 60);
      r = 1'($urandom_range(0, 99) < 50);
      f = 1'($urandom_range(0, 39) == 0);
      b = 1'($urandom);
      cycle(v, mk(pc, b), r, f);
      pc += 4;
    end
    drain();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instruction_queue.md
Name: instruction_queue

Overview:
- Circular FIFO between the instruction decoder and the reservation-station dispatch logic.
- Accepts decoded instruction_element_t entries through a valid/ready handshake and presents the oldest entry to dispatch.
- Tracks how many buffered entries are control-flow (branch=1).
- Discards all contents on a pipeline flush, for example a branch mispredict.

Parameters:
- DEPTH, 8, number of entries; must be a power of two and at least 2.
- PTR_W, $clog2(DEPTH), width of the head/tail index. Derived; not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-low (queue cleared while rst=0)
- flush_i  input  1  discard all entries at the next edge
- enq_vld_i  input  1  decoder presents an instruction
- enq_instr_i  input  instruction_element_t  instruction from the decoder
- enq_rdy_o  output  1  queue can accept an entry this cycle
- deq_vld_o  output  1  oldest entry is valid
- deq_instr_o  output  instruction_element_t  oldest entry
- deq_rdy_i  input  1  dispatch consumes the oldest entry this cycle
- count_o  output  PTR_W+1  number of occupied entries
- br_count_o  output  PTR_W+1  occupied entries with branch=1
- full_o  output  1  count_o == DEPTH
- empty_o  output  1  count_o == 0

Behaviour:
- Storage:
  - DEPTH-entry array; head and tail pointers of PTR_W+1 bits each, with the MSB as the wrap bit.
  - full when the indices are equal and the wrap bits differ.
  - empty when the pointers are fully equal.
- Reset (rst=0, asynchronous):
  - head=tail=0, count_o=0, br_count_o=0.
  - enq_rdy_o=1, deq_vld_o=0, empty_o=1, full_o=0.
  - Array contents are don't-care and are not reset.
- Handshakes:
  - Enqueue fires when enq_vld_i && enq_rdy_o. enq_rdy_o = !full_o; it is combinational only from registered state.
  - Dequeue fires when deq_vld_o && deq_rdy_i. deq_vld_o = !empty_o.
  - deq_instr_o = array[head index] (read from storage, no combinational path from enq_instr_i).
  - deq_instr_o is don't-care when deq_vld_o=0.
- Latency: an entry written at edge N becomes visible on deq_* after edge N, i.e. one cycle minimum. There is no empty-bypass.
- Simultaneous enqueue and dequeue:
  - Both fire in the same cycle when neither full nor empty; count_o is unchanged.
  - When full, enqueue is blocked even if a dequeue fires (no full-bypass).
  - When empty, a dequeue cannot fire.
- Wrap-around: the pointer index wraps from DEPTH-1 to 0, and the wrap bit toggles on each wrap.
- br_count_o:
  - +1 when the enqueued entry has branch=1.
  - -1 when the dequeued entry has branch=1.
  - Both occurring in the same cycle gives a net change of 0.
- Flush:
  - flush_i=1 at an edge sets head=tail=0, count_o=0, br_count_o=0.
  - Any enqueue or dequeue in that cycle is ignored, including a dequeue presented to dispatch.
  - Flush takes priority over every other update.
  - Handshake outputs are not gated by flush_i; dispatch must itself ignore deq_vld_o during a flush cycle.
- Reset asserted mid-operation: the queue clears immediately (asynchronous), with no handshake completing.
- Assertions for the bench: count_o <= DEPTH; br_count_o <= count_o; no enqueue when full; no dequeue when empty.

Test Plan:
- Reset, then enqueue 3 entries (pc=0x100,0x104,0x108) with deq_rdy_i=0 -> count_o=3, deq_instr_o.pc=0x100, deq_vld_o=1 one cycle after the first enqueue.
- Fill DEPTH=8 entries -> full_o=1, enq_rdy_o=0. Assert enq_vld_i and deq_rdy_i together -> only the dequeue fires, count_o=7 next cycle.
- Continuous enqueue and dequeue for 20 cycles with incrementing pc -> dequeued pc sequence is in order with no gaps, pointers wrap past index 7, count_o stays constant.
- Enqueue 5 entries, two with branch=1, then dequeue one branch entry while enqueuing one non-branch entry -> br_count_o goes 2 -> 1, count_o stays 5.
- With 4 entries present, assert flush_i together with enq_vld_i=1 and deq_rdy_i=1 -> next cycle count_o=0, br_count_o=0, empty_o=1, the flushed-cycle enqueued entry never appears.
- Drive rst=0 asynchronously between clock edges with 6 entries queued -> outputs return immediately to reset values. Release rst and enqueue pc=0x200 -> it is the first dequeued entry.
